ifid_pipe_ctrl: RTL and testbench



---
 rtl/ifid_pipe_ctrl_pkg.sv | 20 ++
 rtl/ifid_pipe_ctrl_if.sv | 26 ++
 rtl/ifid_pipe_ctrl_stall_watchdog.sv | 42 ++++
 rtl/ifid_pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_ifid_pipe_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ifid_pipe_ctrl_pkg.sv
// Shared pipeline definitions: IF/ID controller states, width defaults and
// the memory/immediate opcodes the hazard unit also decodes.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    SQUASH = 2'd2
  } ifid_state_t;

  localparam int               INST_W_DEF   = 16;
  localparam int               PC_W_DEF     = 16;
  localparam logic [15:0]      NOP_INST_DEF = 16'h0000;

  localparam logic [3:0] LW  = 4'b1000;
  localparam logic [3:0] SW  = 4'b1001;
  localparam logic [3:0] LHB = 4'b1010;
  localparam logic [3:0] LLB = 4'b1011;

endpackage

// File: rtl/ifid_pipe_ctrl_if.sv
// Fetch/hazard-unit/decode signals seen by the IF/ID controller.
interface ifid_pipe_ctrl_if #(
  parameter int INST_W = 16,
  parameter int PC_W   = 16
);
  logic              stall;
  logic              flush;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] ifid_inst;
  logic [PC_W-1:0]   ifid_pc;
  logic              ifid_valid;
  logic              pc_we;
  logic              idex_bubble;
  logic              stall_timeout;

  modport master (
    output stall, flush, if_inst, if_pc,
    input  ifid_inst, ifid_pc, ifid_valid, pc_we, idex_bubble, stall_timeout
  );

  modport slave (
    input  stall, flush, if_inst, if_pc,
    output ifid_inst, ifid_pc, ifid_valid, pc_we, idex_bubble, stall_timeout
  );
endinterface

// File: rtl/ifid_pipe_ctrl_stall_watchdog.sv
// Counts consecutive stall cycles (saturating) and raises a sticky timeout
// once the count reaches MAX_STALL.
module stall_watchdog #(
  parameter int MAX_STALL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic timeout
);
  localparam int               CNT_W   = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;

  always_comb begin
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (count_en && cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + 1'b1;
    end
    if (cnt_next == CNT_MAX) begin
      timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
endmodule

// File: rtl/ifid_pipe_ctrl.sv
// IF/ID pipeline register and PC write control driven by hazard stall/flush.
// Define IFID_PERF_CNT_EN to add stall_cycles / flush_events counters.
module ifid_pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int                INST_W      = INST_W_DEF,
  parameter int                PC_W        = PC_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST    = INST_W'(NOP_INST_DEF),
  parameter int                FLUSH_DEPTH = 1,
  parameter int                MAX_STALL   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ifid_pipe_ctrl_if.slave  bus
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_events
`endif
);
  localparam logic [1:0] SQ_INIT = 2'(FLUSH_DEPTH - 1);

  ifid_state_t       state_reg, state_next;
  logic [1:0]        sq_cnt_reg, sq_cnt_next;
  logic [INST_W-1:0] ifid_inst_reg;
  logic [PC_W-1:0]   ifid_pc_reg;
  logic              ifid_valid_reg;
  logic              load_fetch, load_nop, stall_eff;
  logic              pc_we, idex_bubble;

  // Stall only counts when it is not overridden by flush or masked in SQUASH.
  assign stall_eff = bus.stall && !bus.flush && (state_reg != SQUASH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      sq_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sq_cnt_reg <= sq_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sq_cnt_next = sq_cnt_reg;
    if (bus.flush) begin
      if (FLUSH_DEPTH > 1) begin
        state_next  = SQUASH;
        sq_cnt_next = SQ_INIT;
      end else begin
        state_next = RUN;
      end
    end else begin
      case (state_reg)
        RUN, STALL: state_next = bus.stall ? STALL : RUN;
        SQUASH: begin
          sq_cnt_next = sq_cnt_reg - 2'd1;
          if (sq_cnt_reg <= 2'd1) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    pc_we       = 1'b0;
    idex_bubble = 1'b0;
    load_fetch  = 1'b0;
    load_nop    = 1'b0;
    if (!rst_n) begin
      pc_we = 1'b0;
    end else if (bus.flush) begin
      pc_we       = 1'b1;
      idex_bubble = 1'b1;
      load_nop    = 1'b1;
    end else if (state_reg == SQUASH) begin
      pc_we    = 1'b1;
      load_nop = 1'b1;
    end else if (bus.stall) begin
      idex_bubble = 1'b1;
    end else begin
      pc_we      = 1'b1;
      load_fetch = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_inst_reg  <= NOP_INST;
      ifid_pc_reg    <= '0;
      ifid_valid_reg <= 1'b0;
    end else if (load_fetch) begin
      ifid_inst_reg  <= bus.if_inst;
      ifid_pc_reg    <= bus.if_pc;
      ifid_valid_reg <= 1'b1;
    end else if (load_nop) begin
      ifid_inst_reg  <= NOP_INST;
      ifid_pc_reg    <= bus.if_pc;
      ifid_valid_reg <= 1'b0;
    end
  end

  stall_watchdog #(.MAX_STALL(MAX_STALL)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (stall_eff),
    .clear    (!stall_eff),
    .timeout  (bus.stall_timeout)
  );

  assign bus.ifid_inst   = ifid_inst_reg;
  assign bus.ifid_pc     = ifid_pc_reg;
  assign bus.ifid_valid  = ifid_valid_reg;
  assign bus.pc_we       = pc_we;
  assign bus.idex_bubble = idex_bubble;

`ifdef IFID_PERF_CNT_EN
  logic [1:0]  perf_inc;
  logic [15:0] perf_cnt_reg [2];

  assign perf_inc = {bus.flush, stall_eff};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          perf_cnt_reg[gi] <= '0;
        end else if (perf_inc[gi] && perf_cnt_reg[gi] != 16'hFFFF) begin
          perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign stall_cycles = perf_cnt_reg[0];
  assign flush_events = perf_cnt_reg[1];
`endif
endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Directed-vector bench with a scoreboard queue; one DUT per flush depth.
module tb_ifid_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifid_pipe_ctrl_if #(.INST_W(16), .PC_W(16)) bus1 ();
  ifid_pipe_ctrl_if #(.INST_W(16), .PC_W(16)) bus3 ();

`ifdef IFID_PERF_CNT_EN
  logic [15:0] sc1, fe1, sc3, fe3;
`endif

  ifid_pipe_ctrl #(.FLUSH_DEPTH(1), .MAX_STALL(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
`ifdef IFID_PERF_CNT_EN
    , .stall_cycles (sc1), .flush_events (fe1)
`endif
  );

  ifid_pipe_ctrl #(.FLUSH_DEPTH(3), .MAX_STALL(4)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
`ifdef IFID_PERF_CNT_EN
    , .stall_cycles (sc3), .flush_events (fe3)
`endif
  );

  typedef struct {
    int          idx;
    bit          sel;
    logic [15:0] inst;
    logic [15:0] pc;
    logic        valid;
    logic        we;
    logic        bub;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_n = 0;

  task automatic chk(input int idx, input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL vec%0d %s actual=%h required=%h", idx, name, act, req);
    end
  endtask

  // Inputs for one cycle plus the outputs expected at that cycle's negedge.
  task automatic step(input bit r, input bit sel, input bit st, input bit fl,
                      input logic [15:0] inst, input logic [15:0] pc,
                      input logic [15:0] e_inst, input logic [15:0] e_pc,
                      input bit e_v, input bit e_we, input bit e_bub, input bit e_to);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    bus1.stall = st;  bus1.flush = fl;  bus1.if_inst = inst;  bus1.if_pc = pc;
    bus3.stall = st;  bus3.flush = fl;  bus3.if_inst = inst;  bus3.if_pc = pc;
    e.idx = vec_n; e.sel = sel; e.inst = e_inst; e.pc = e_pc;
    e.valid = e_v; e.we = e_we; e.bub = e_bub; e.to = e_to;
    exp_q.push_back(e);
    vec_n++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [15:0] a_inst, a_pc;
      logic a_v, a_we, a_bub, a_to;
      e = exp_q.pop_front();
      if (e.sel) begin
        a_inst = bus3.ifid_inst; a_pc = bus3.ifid_pc; a_v = bus3.ifid_valid;
        a_we = bus3.pc_we; a_bub = bus3.idex_bubble; a_to = bus3.stall_timeout;
      end else begin
        a_inst = bus1.ifid_inst; a_pc = bus1.ifid_pc; a_v = bus1.ifid_valid;
        a_we = bus1.pc_we; a_bub = bus1.idex_bubble; a_to = bus1.stall_timeout;
      end
      $display("vec%0d dut%0d inst=%h pc=%h valid=%b pc_we=%b bubble=%b timeout=%b",
               e.idx, e.sel ? 3 : 1, a_inst, a_pc, a_v, a_we, a_bub, a_to);
      chk(e.idx, "ifid_inst",     a_inst,       e.inst);
      chk(e.idx, "ifid_pc",       a_pc,         e.pc);
      chk(e.idx, "ifid_valid",    16'(a_v),     16'(e.valid));
      chk(e.idx, "pc_we",         16'(a_we),    16'(e.we));
      chk(e.idx, "idex_bubble",   16'(a_bub),   16'(e.bub));
      chk(e.idx, "stall_timeout", 16'(a_to),    16'(e.to));
    end
  end

  initial begin
    bus1.stall = 0; bus1.flush = 0; bus1.if_inst = 16'h1234; bus1.if_pc = 16'h0002;
    bus3.stall = 0; bus3.flush = 0; bus3.if_inst = 16'h1234; bus3.if_pc = 16'h0002;
    //     rst sel st fl inst     pc        e_inst   e_pc     v we bb to
    step(0, 0, 0, 0, 16'h1234, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 16'h1234, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h1234, 16'h0002, 16'h0000, 16'h0000, 0, 1, 0, 0);
    step(1, 0, 0, 0, 16'hA001, 16'h0004, 16'h1234, 16'h0002, 1, 1, 0, 0);
    step(1, 0, 1, 0, 16'hA003, 16'h0006, 16'hA001, 16'h0004, 1, 0, 1, 0);
    step(1, 0, 0, 0, 16'hA003, 16'h0006, 16'hA001, 16'h0004, 1, 1, 0, 0);
    step(1, 0, 0, 0, 16'hA005, 16'h0008, 16'hA003, 16'h0006, 1, 1, 0, 0);
    // four consecutive stalls reach MAX_STALL
    for (int i = 0; i < 4; i++)
      step(1, 0, 1, 0, 16'hB001, 16'h000A, 16'hA005, 16'h0008, 1, 0, 1, 0);
    step(1, 0, 0, 0, 16'hB001, 16'h000A, 16'hA005, 16'h0008, 1, 1, 0, 1);
    step(1, 0, 0, 0, 16'hB003, 16'h000C, 16'hB001, 16'h000A, 1, 1, 0, 1);
    // stall and flush together: flush wins
    step(1, 0, 1, 1, 16'hC0FE, 16'h0020, 16'hB003, 16'h000C, 1, 1, 1, 1);
    step(1, 0, 0, 0, 16'hD001, 16'h0022, 16'h0000, 16'h0020, 0, 1, 0, 1);
    step(1, 0, 0, 0, 16'hD003, 16'h0024, 16'hD001, 16'h0022, 1, 1, 0, 1);
    // asynchronous reset clears the sticky timeout and the register
    step(0, 0, 0, 0, 16'hE001, 16'h0030, 16'h0000, 16'h0000, 0, 0, 0, 0);
    step(1, 0, 0, 0, 16'hE001, 16'h0030, 16'h0000, 16'h0000, 0, 1, 0, 0);
    // 3 stalls, flush, 3 stalls: flush must clear the stall count
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 0, 16'hE003, 16'h0032, 16'hE001, 16'h0030, 1, 0, 1, 0);
    step(1, 0, 1, 1, 16'hE005, 16'h0034, 16'hE001, 16'h0030, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 0, 16'hE007, 16'h0036, 16'h0000, 16'h0034, 0, 0, 1, 0);
    step(1, 0, 0, 0, 16'hE007, 16'h0036, 16'h0000, 16'h0034, 0, 1, 0, 0);
    step(1, 0, 0, 0, 16'hE009, 16'h0038, 16'hE007, 16'h0036, 1, 1, 0, 0);
    // FLUSH_DEPTH=3 instance
    step(0, 1, 0, 0, 16'hF001, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0, 0);
    step(1, 1, 0, 0, 16'hF001, 16'h0040, 16'h0000, 16'h0000, 0, 1, 0, 0);
    step(1, 1, 0, 1, 16'hF003, 16'h0042, 16'hF001, 16'h0040, 1, 1, 1, 0);
    step(1, 1, 0, 0, 16'hF005, 16'h0044, 16'h0000, 16'h0042, 0, 1, 0, 0);
    step(1, 1, 1, 0, 16'hF007, 16'h0046, 16'h0000, 16'h0044, 0, 1, 0, 0);
    step(1, 1, 0, 0, 16'hF009, 16'h0048, 16'h0000, 16'h0046, 0, 1, 0, 0);
    step(1, 1, 0, 0, 16'hF00B, 16'h004A, 16'hF009, 16'h0048, 1, 1, 0, 0);
    // flush during SQUASH restarts the squash count
    step(1, 1, 0, 1, 16'h1111, 16'h0050, 16'hF00B, 16'h004A, 1, 1, 1, 0);
    step(1, 1, 0, 0, 16'h2222, 16'h0052, 16'h0000, 16'h0050, 0, 1, 0, 0);
    step(1, 1, 0, 1, 16'h3333, 16'h0054, 16'h0000, 16'h0052, 0, 1, 1, 0);
    step(1, 1, 0, 0, 16'h4444, 16'h0056, 16'h0000, 16'h0054, 0, 1, 0, 0);
    step(1, 1, 0, 0, 16'h5555, 16'h0058, 16'h0000, 16'h0056, 0, 1, 0, 0);
    step(1, 1, 0, 0, 16'h6666, 16'h005A, 16'h0000, 16'h0058, 0, 1, 0, 0);
    step(1, 1, 0, 0, 16'h7777, 16'h005C, 16'h6666, 16'h005A, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
`ifdef IFID_PERF_CNT_EN
    // Since the last reset: one stall bubble (dut1 only), three flushes.
    chk(-1, "dut1_stall_cycles", sc1, 16'd1);
    chk(-1, "dut1_flush_events", fe1, 16'd3);
    chk(-1, "dut3_stall_cycles", sc3, 16'd0);
    chk(-1, "dut3_flush_events", fe3, 16'd3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
